// File: rtl/rf_wb_buffer_pkg.sv
// Shared definitions for the register-file write-back buffer.
// The register file has 8 entries and a 16-bit default data width.
package rf_wb_buffer_pkg;

    localparam int REG_SEL_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int WIDTH_DEF = 16;

    typedef logic [REG_SEL_W-1:0] regsel_t;

    // One queued register-file write at the default width.
    typedef struct packed {
        regsel_t              regsel;
        logic [WIDTH_DEF-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_lookup.sv
// Newest-match search over the write-back queue for one forwarding port.
// Entries are scanned oldest to newest from head, so the last match wins.
module rf_wb_lookup
    import rf_wb_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [PTR_W-1:0]           head_i,
    input  logic [DEPTH-1:0]           valid_i,
    input  logic [DEPTH*REG_SEL_W-1:0] regsel_i,
    input  logic [DEPTH*WIDTH-1:0]     data_i,
    input  logic [REG_SEL_W-1:0]       sel_i,
    output logic                       hit_o,
    output logic [WIDTH-1:0]           data_o
);

    logic [DEPTH-1:0] match;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = valid_i[gi] &&
                               (regsel_i[gi*REG_SEL_W +: REG_SEL_W] == sel_i);
        end
    endgenerate

    always_comb begin
        logic [PTR_W-1:0] idx;
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_i + PTR_W'(k);
            if (match[idx]) begin
                hit_o  = 1'b1;
                data_o = data_i[idx*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/rf_wb_buffer.sv
// In-order write-back queue in front of the register file write port,
// with two forwarding lookups that expose pending values to readers.
module rf_wb_buffer
    import rf_wb_buffer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_SEL_W-1:0] in_regsel,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 drain_en,
    output logic                 wr_en,
    output logic [REG_SEL_W-1:0] wr_regsel,
    output logic [WIDTH-1:0]     wr_data,
    input  logic [REG_SEL_W-1:0] fwd1_sel,
    output logic                 fwd1_hit,
    output logic [WIDTH-1:0]     fwd1_data,
    input  logic [REG_SEL_W-1:0] fwd2_sel,
    output logic                 fwd2_hit,
    output logic [WIDTH-1:0]     fwd2_data,
    output logic [CNT_W-1:0]     count,
    output logic                 err
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic             err_q, err_d;

    logic [REG_SEL_W-1:0] entry_regsel_q [DEPTH];
    logic [WIDTH-1:0]     entry_data_q   [DEPTH];

    logic [DEPTH*REG_SEL_W-1:0] regsel_flat;
    logic [DEPTH*WIDTH-1:0]     data_flat;

    logic not_empty;
    logic push;
    logic drain;

    assign not_empty = (count_q != '0);
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign drain     = not_empty && drain_en;

    assign wr_en     = drain;
    assign wr_regsel = not_empty ? entry_regsel_q[head_q] : '0;
    assign wr_data   = not_empty ? entry_data_q[head_q]   : '0;
    assign count     = count_q;
    assign err       = err_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(drain);
        valid_d = valid_q;
        err_d   = in_valid && !in_ready;
        // Clear before set: head and tail only coincide when empty or full,
        // and in those states at most one of push/drain can fire.
        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end
        if (push) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    // Payload needs no reset; the valid bits and count gate every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_regsel_q[tail_q] <= in_regsel;
            entry_data_q[tail_q]   <= in_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flat
            assign regsel_flat[gi*REG_SEL_W +: REG_SEL_W] = entry_regsel_q[gi];
            assign data_flat[gi*WIDTH +: WIDTH]           = entry_data_q[gi];
        end
    endgenerate

    rf_wb_lookup #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lookup1 (
        .head_i   (head_q),
        .valid_i  (valid_q),
        .regsel_i (regsel_flat),
        .data_i   (data_flat),
        .sel_i    (fwd1_sel),
        .hit_o    (fwd1_hit),
        .data_o   (fwd1_data)
    );

    rf_wb_lookup #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_lookup2 (
        .head_i   (head_q),
        .valid_i  (valid_q),
        .regsel_i (regsel_flat),
        .data_i   (data_flat),
        .sel_i    (fwd2_sel),
        .hit_o    (fwd2_hit),
        .data_o   (fwd2_data)
    );

endmodule
